// File: rtl/raspi_link_pkg.sv
// Shared types and constants for the Raspberry Pi parallel GPIO receive link.
package raspi_link_pkg;

    localparam int   RX_ENTRY_W = 9;     // {cmd, byte}
    localparam logic SEL_CMD    = 1'b1;
    localparam logic SEL_DATA   = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH,
        ST_WAIT_SPACE,
        ST_ACK,
        ST_WAIT_LOW
    } rx_state_e;

endpackage

// File: rtl/raspi_rx_fifo.sv
// First-word fall-through FIFO for received {cmd, byte} entries.
module raspi_rx_fifo
    import raspi_link_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [RX_ENTRY_W-1:0]         wr_data,
    input  logic                          rd_en,
    output logic [RX_ENTRY_W-1:0]         rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fill
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FILL_W = PTR_W + 1;

    logic [RX_ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [FILL_W-1:0]     fill_q;
    logic                  pop;
    logic                  push;

    assign empty = (fill_q == '0);
    assign full  = (fill_q == FILL_W'(FIFO_DEPTH));
    assign fill  = fill_q;

    // A pop frees its slot in the same cycle, so a full FIFO can still take a write.
    assign pop  = rd_en & ~empty;
    assign push = wr_en & (~full | pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/raspi_gpio_rx.sv
// Receive stage for the Pi parallel GPIO link: synchronisers, 4-phase
// req/ack handshake FSM, strobe timeout and an output byte FIFO.
module raspi_gpio_rx
    import raspi_link_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    raspi_gpiox8,
    input  logic                          rasp0_i,
    input  logic                          rasp1_i,
    output logic                          ack_o,
    output logic [7:0]                    byte_o,
    output logic                          cmd_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fill_o,
    output logic                          timeout_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CYC);

    logic [9:0]             sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] warm_q;
    logic                   armed_q;
    logic                   stb_prev_q;
    logic                   stb_s;
    logic                   stb_rise;

    rx_state_e              state_q, state_d;
    logic                   latch_en;
    logic                   wr_en;
    logic [RX_ENTRY_W-1:0]  entry_q;
    logic                   ack_q;
    logic [CNT_W-1:0]       tmo_cnt_q;
    logic                   timeout_q;

    logic [RX_ENTRY_W-1:0]  head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   space;

    // Input synchronisers: {strobe, select, data}
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {rasp0_i, rasp1_i, raspi_gpiox8};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign stb_s = sync_q[SYNC_STAGES-1][9];

    // Edge detection is armed only once the synchroniser holds real pin
    // samples and the strobe has been seen low, so a strobe still high
    // across reset is never taken as a fresh request.
    always_ff @(posedge clk) begin
        if (rst) begin
            warm_q     <= '0;
            armed_q    <= 1'b0;
            stb_prev_q <= 1'b0;
        end else begin
            warm_q     <= {warm_q[SYNC_STAGES-2:0], 1'b1};
            stb_prev_q <= stb_s;
            if (warm_q[SYNC_STAGES-1] && !stb_s) armed_q <= 1'b1;
        end
    end

    assign stb_rise = armed_q & stb_s & ~stb_prev_q;
    assign space    = ~fifo_full | (~fifo_empty & ready_i);

    always_comb begin
        state_d  = state_q;
        latch_en = 1'b0;
        wr_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (stb_rise) begin
                    latch_en = 1'b1;
                    state_d  = ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (!fifo_full) begin
                    wr_en   = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_WAIT_SPACE;
                end
            end
            ST_WAIT_SPACE: begin
                if (space) begin
                    wr_en   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK:      state_d = ST_WAIT_LOW;
            ST_WAIT_LOW: if (!stb_s) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= (state_d == ST_ACK) || (state_d == ST_WAIT_LOW);
        end
    end

    always_ff @(posedge clk) begin
        if (latch_en) entry_q <= sync_q[SYNC_STAGES-1][8:0];
    end

    // Strobe-high watchdog; counts only while waiting for the strobe to fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else if (state_q == ST_WAIT_LOW) begin
            if (tmo_cnt_q != TMO_MAX) tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (tmo_cnt_q == TMO_MAX - 1'b1) timeout_q <= 1'b1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    raspi_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (entry_q),
        .rd_en   (ready_i),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .fill    (fill_o)
    );

    assign ack_o     = ack_q;
    assign valid_o   = ~fifo_empty;
    assign byte_o    = head[7:0];
    assign cmd_o     = head[8];
    assign timeout_o = timeout_q;

endmodule
